sha256_block_padder: RTL and testbench

- Upstream feeder for the SHA-256 compression datapath.
- Reads a word-aligned message of num_words 32-bit words from the shared word-addressed memory.
- Applies standard SHA-256 padding: a 0x80000000 marker word, zero fill, then a 64-bit big-endian bit length.
- Streams the resulting 512-bit blocks to the consumer over a valid/ready handshake, one block at a time.

---
 rtl/sha256_pkg.sv | 28 ++
 rtl/sha256_block_padder_if.sv | 50 +++++
 rtl/sha256_block_padder.sv | 221 ++++++++++++++++++++++
 tb/tb_sha256_block_padder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 block padder.
// Holds the word/block geometry, the padding marker word, the block payload
// type, the controller state encoding and the block-count helper.
package sha256_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BLOCK_WORDS = 16;
    localparam int unsigned BLOCK_W     = WORD_W * BLOCK_WORDS;
    localparam int unsigned CNT_W       = 5;
    localparam int unsigned IDX_W       = 16;

    localparam logic [WORD_W-1:0] SHA256_PAD_WORD = 32'h8000_0000;

    typedef logic [BLOCK_W-1:0] sha256_block_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PRESENT,
        FIN
    } state_t;

    // Blocks needed for n message words: marker word plus 64-bit length.
    function automatic logic [IDX_W-1:0] block_count(input logic [15:0] n);
        return IDX_W'((32'(n) + 32'd18) >> 4);
    endfunction

endpackage

// File: rtl/sha256_block_padder_if.sv
// Bus bundle between the padder, the shared word memory and the block consumer.
//   mem_clk/mem_we/mem_addr : padder -> memory (read-only access)
//   mem_read_data           : memory -> padder, one cycle after mem_addr
//   blk_valid/blk_data/blk_first/blk_last/blk_index : padder -> consumer
//   blk_ready               : consumer -> padder
interface sha256_block_padder_if
    import sha256_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
);

    logic                mem_clk;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_read_data;

    logic                blk_valid;
    logic                blk_ready;
    sha256_block_t       blk_data;
    logic                blk_first;
    logic                blk_last;
    logic [IDX_W-1:0]    blk_index;

    modport master (
        output mem_clk,
        output mem_we,
        output mem_addr,
        input  mem_read_data,
        output blk_valid,
        input  blk_ready,
        output blk_data,
        output blk_first,
        output blk_last,
        output blk_index
    );

    modport slave (
        input  mem_clk,
        input  mem_we,
        input  mem_addr,
        output mem_read_data,
        input  blk_valid,
        output blk_ready,
        input  blk_data,
        input  blk_first,
        input  blk_last,
        input  blk_index
    );

endinterface

// File: rtl/sha256_block_padder.sv
// SHA-256 message padder: reads num_words words from memory starting at
// message_addr, appends the 0x80000000 marker, zero fill and the bit length,
// and hands out 512-bit blocks one at a time over valid/ready.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   start, message_addr,
//   num_words               : request (sampled in IDLE only)
//   busy, done, err         : status; done pulses once, err rides with done
//   bus (master)            : memory read port and block output stream
module sha256_block_padder
    import sha256_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     message_addr,
    input  logic [15:0]           num_words,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    sha256_block_padder_if.master bus
);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [15:0]        nwords_q, nwords_d;
    logic [IDX_W-1:0]   nblk_q, nblk_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               v0_q, v0_d, v1_q, v1_d;
    logic [3:0]         i0_q, i0_d, i1_q, i1_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    sha256_block_t      data_q, data_d;
    logic               valid_q, valid_d;
    logic               first_q, first_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [20:0]        g_base;
    logic [20:0]        n_ext;
    logic [20:0]        rem;
    logic [CNT_W-1:0]   m;
    logic               is_last;
    logic               fill_end;
    logic [WORD_W-1:0]  len_word;
    logic [WORD_W-1:0]  pad_word;

    // Per-block geometry: global index of word 0 and message words in this block.
    always_comb begin
        g_base   = {1'b0, index_q, 4'b0000};
        n_ext    = 21'(nwords_q);
        rem      = n_ext - g_base;
        m        = '0;
        if (n_ext > g_base) begin
            m = (rem >= 21'd16) ? CNT_W'(16) : rem[CNT_W-1:0];
        end
        is_last  = (index_q == nblk_q - IDX_W'(1));
        len_word = 32'(nwords_q) << 5;
        // Without message words the padding is written in the single first cycle.
        fill_end = (m == '0) ? (cnt_q == '0) : (cnt_q == m + CNT_W'(1));
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        nwords_d = nwords_q;
        nblk_d   = nblk_q;
        index_d  = index_q;
        cnt_d    = cnt_q;
        v0_d     = 1'b0;
        i0_d     = cnt_q[3:0];
        v1_d     = v0_q;
        i1_d     = i0_q;
        addr_d   = addr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        first_d  = first_q;
        last_d   = last_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        pad_word = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (32'(num_words) > MAX_WORDS) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        base_d   = message_addr;
                        nwords_d = num_words;
                        nblk_d   = block_count(num_words);
                        index_d  = '0;
                        cnt_d    = '0;
                        state_d  = FILL;
                    end
                end
            end

            FILL: begin
                // Word issued two edges earlier is on mem_read_data now.
                if (v1_q) begin
                    data_d[WORD_W*(BLOCK_WORDS-1-32'(i1_q)) +: WORD_W] = bus.mem_read_data;
                end
                if (cnt_q < m) begin
                    addr_d = base_q + ADDR_W'(g_base) + ADDR_W'(cnt_q);
                    v0_d   = 1'b1;
                end
                if (fill_end) begin
                    // Every word at or past m is padding; disjoint from captured words.
                    for (int w = 0; w < 16; w++) begin
                        if (CNT_W'(w) >= m) begin
                            if (g_base + 21'(w) == n_ext) begin
                                pad_word = SHA256_PAD_WORD;
                            end else if (is_last && (w == 15)) begin
                                pad_word = len_word;
                            end else begin
                                pad_word = '0;
                            end
                            data_d[WORD_W*(BLOCK_WORDS-1-32'(w)) +: WORD_W] = pad_word;
                        end
                    end
                    valid_d = 1'b1;
                    first_d = (index_q == '0);
                    last_d  = is_last;
                    state_d = PRESENT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PRESENT: begin
                if (bus.blk_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                        cnt_d   = '0;
                        state_d = FILL;
                    end
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == FILL) || (state_d == PRESENT);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            base_q   <= '0;
            nwords_q <= '0;
            nblk_q   <= '0;
            index_q  <= '0;
            cnt_q    <= '0;
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
            i0_q     <= '0;
            i1_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            nwords_q <= nwords_d;
            nblk_q   <= nblk_d;
            index_q  <= index_d;
            cnt_q    <= cnt_d;
            v0_q     <= v0_d;
            v1_q     <= v1_d;
            i0_q     <= i0_d;
            i1_q     <= i1_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            first_q  <= first_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

    assign bus.mem_clk   = clk;
    assign bus.mem_we    = 1'b0;
    assign bus.mem_addr  = addr_q;
    assign bus.blk_valid = valid_q;
    assign bus.blk_data  = data_q;
    assign bus.blk_first = first_q;
    assign bus.blk_last  = last_q;
    assign bus.blk_index = index_q;

endmodule

// File: tb/tb_sha256_block_padder.sv
// Self-checking bench for sha256_block_padder: synchronous-read memory model,
// reference block builder from the padding rules, directed and random messages.
module tb_sha256_block_padder;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] message_addr;
    logic [15:0] num_words;
    logic        busy;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [0:65535];

    sha256_block_padder_if #(.ADDR_W(16)) bus ();

    sha256_block_padder #(.MAX_WORDS(1024), .ADDR_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .message_addr (message_addr),
        .num_words    (num_words),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: data for an address appears one edge later.
    always @(posedge clk) bus.mem_read_data <= mem[bus.mem_addr];

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [511:0] blk, input int w);
        return blk[511-32*w -: 32];
    endfunction

    // Expected block b for a message of n words at base, straight from the padding rules.
    function automatic logic [511:0] exp_block(input logic [15:0] base, input int n, input int b);
        logic [511:0] blk;
        logic [31:0]  wd;
        int           g;
        int           nb;
        nb  = (n + 18) / 16;
        blk = '0;
        for (int w = 0; w < 16; w++) begin
            g = 16 * b + w;
            if (g < n)                          wd = mem[16'(int'(base) + g)];
            else if (g == n)                    wd = 32'h8000_0000;
            else if (b == nb - 1 && w == 15)    wd = 32'(n * 32);
            else                                wd = 32'h0;
            blk[511-32*w -: 32] = wd;
        end
        return blk;
    endfunction

    task automatic do_msg(input logic [15:0] base, input int n, input int stall, input bit poke);
        int           nb;
        int           lat;
        int           m;
        logic [511:0] exp;
        message_addr = base;
        num_words    = 16'(n);
        start        = 1'b1;
        tick();
        start        = 1'b0;
        if (n > 1024) begin
            chk("rej_done", 512'(done), 512'd1);
            chk("rej_err", 512'(err), 512'd1);
            chk("rej_busy", 512'(busy), 512'd0);
            chk("rej_valid", 512'(bus.blk_valid), 512'd0);
            tick();
            chk("rej_done_pulse", 512'(done), 512'd0);
            chk("rej_valid_after", 512'(bus.blk_valid), 512'd0);
            return;
        end
        chk("busy_after_start", 512'(busy), 512'd1);
        nb = (n + 18) / 16;
        for (int b = 0; b < nb; b++) begin
            m = n - 16 * b;
            if (m < 0)  m = 0;
            if (m > 16) m = 16;
            lat = 0;
            while (!bus.blk_valid && lat < 64) begin
                tick();
                lat++;
            end
            chk("fill_latency", 512'(lat), 512'((m == 0) ? 1 : m + 2));
            if (!bus.blk_valid) return;
            exp = exp_block(base, n, b);
            chk("blk_data", bus.blk_data, exp);
            chk("blk_first", 512'(bus.blk_first), 512'(b == 0));
            chk("blk_last", 512'(bus.blk_last), 512'(b == nb - 1));
            chk("blk_index", 512'(bus.blk_index), 512'(b));
            if (stall > 0 && b == 0) begin
                bus.blk_ready = 1'b0;
                for (int c = 0; c < stall; c++) begin
                    if (poke && c == 3) begin
                        start     = 1'b1;
                        num_words = 16'd3;
                    end
                    tick();
                    start     = 1'b0;
                    num_words = 16'(n);
                    chk("stall_valid", 512'(bus.blk_valid), 512'd1);
                    chk("stall_data", bus.blk_data, exp);
                end
                bus.blk_ready = 1'b1;
            end
            tick();
        end
        chk("done_pulse", 512'(done), 512'd1);
        chk("done_err", 512'(err), 512'd0);
        chk("done_busy", 512'(busy), 512'd0);
        tick();
        chk("done_clear", 512'(done), 512'd0);
    endtask

    initial begin
        int lat;
        reset_n       = 1'b0;
        start         = 1'b0;
        message_addr  = '0;
        num_words     = '0;
        bus.blk_ready = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        for (int i = 0; i < 32; i++) mem[i] = 32'(i);

        tick();
        tick();
        chk("rst_busy", 512'(busy), 512'd0);
        chk("rst_done", 512'(done), 512'd0);
        chk("rst_err", 512'(err), 512'd0);
        chk("rst_valid", 512'(bus.blk_valid), 512'd0);
        chk("rst_data", bus.blk_data, 512'd0);
        chk("rst_index", 512'(bus.blk_index), 512'd0);
        chk("rst_first_last", 512'({bus.blk_first, bus.blk_last}), 512'd0);
        chk("rst_mem_addr", 512'(bus.mem_addr), 512'd0);
        chk("rst_mem_we", 512'(bus.mem_we), 512'd0);
        reset_n = 1'b1;
        tick();

        do_msg(16'h0000, 20, 0, 1'b0);
        chk("tp20_b1_w0", 512'(word_of(bus.blk_data, 0)), 512'h10);
        chk("tp20_b1_w3", 512'(word_of(bus.blk_data, 3)), 512'h13);
        chk("tp20_b1_w4", 512'(word_of(bus.blk_data, 4)), 512'h8000_0000);
        chk("tp20_b1_w15", 512'(word_of(bus.blk_data, 15)), 512'h280);

        do_msg(16'h0040, 13, 0, 1'b0);
        chk("tp13_w13", 512'(word_of(bus.blk_data, 13)), 512'h8000_0000);
        chk("tp13_w14", 512'(word_of(bus.blk_data, 14)), 512'h0);
        chk("tp13_w15", 512'(word_of(bus.blk_data, 15)), 512'h1A0);

        do_msg(16'h0200, 14, 0, 1'b0);
        chk("tp14_b1", bus.blk_data, 512'h1C0);

        do_msg(16'h0300, 15, 0, 1'b0);
        do_msg(16'h0400, 0, 0, 1'b0);
        chk("tp0_block", bus.blk_data, {32'h8000_0000, 480'h0});

        do_msg(16'h0500, 1025, 0, 1'b0);
        do_msg(16'hFFF8, 20, 0, 1'b0);
        do_msg(16'h1000, 1024, 0, 1'b0);

        do_msg(16'h0000, 20, 10, 1'b1);
        chk("poke_idle_busy", 512'(busy), 512'd0);

        for (int r = 0; r < 6; r++) begin
            do_msg(16'($urandom), int'($urandom_range(0, 70)), int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset during the fill of block 1.
        message_addr = 16'h0100;
        num_words    = 16'd20;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        lat = 0;
        while (!bus.blk_valid && lat < 64) begin
            tick();
            lat++;
        end
        chk("rstmid_b0_valid", 512'(bus.blk_valid), 512'd1);
        tick();
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstmid_busy", 512'(busy), 512'd0);
        chk("rstmid_valid", 512'(bus.blk_valid), 512'd0);
        chk("rstmid_data", bus.blk_data, 512'd0);
        chk("rstmid_addr", 512'(bus.mem_addr), 512'd0);
        chk("rstmid_index", 512'(bus.blk_index), 512'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rstmid_no_done", 512'({done, bus.blk_valid}), 512'd0);
        end
        reset_n = 1'b1;
        tick();
        do_msg(16'h0700, 13, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
